ramb16_s36_stream_reader: RTL and testbench

Port-B read engine for a RAMB16_S2_S36 dual-port block RAM. It sits directly downstream of the RAM's 36-bit port B. On a START command it fetches LEN consecutive 36-bit words, starting at BASE and wrapping at the 512-word boundary, and emits them on a valid/ready stream with a last marker. The port-A (2-bit) side belongs to the upstream producer and is outside this block.

---
 rtl/ramb16_rd_pkg.sv | 24 ++
 rtl/ramb16_rd_skid.sv | 48 ++++
 rtl/ramb16_s36_stream_reader.sv | 131 +++++++++++++
 tb/tb_ramb16_s36_stream_reader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ramb16_rd_pkg.sv
// Shared types, widths and parity helpers for the RAMB16 port-B stream reader.
package ramb16_rd_pkg;

    localparam int ADDR_W = 9;
    localparam int LEN_W  = 10;
    localparam int DATA_W = 36;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    // Even parity of one byte: the parity bit that makes the 9-bit group even.
    function automatic logic byte_par(input logic [7:0] b);
        return ^b;
    endfunction

    function automatic logic word_par_err(input logic [31:0] d, input logic [3:0] p);
        logic err;
        err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            err = err | (p[i] != byte_par(d[8*i +: 8]));
        end
        return err;
    endfunction

endpackage

// File: rtl/ramb16_rd_skid.sv
// Two-entry FIFO holding {last, parity, data} words between the RAM read pipe and the stream.
module ramb16_rd_skid
    import ramb16_rd_pkg::*;
#(
    parameter int W = DATA_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [1:0]   occ
);

    logic [W-1:0] mem0;
    logic [W-1:0] mem1;
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         pop;

    assign rd_valid = (count != 2'd0);
    assign pop      = rd_valid & rd_ready;
    assign rd_data  = rd_ptr ? mem1 : mem0;
    assign occ      = count;

    // The head entry only moves on pop, so an unaccepted word stays put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem0   <= '0;
            mem1   <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) begin
                if (wr_ptr) mem1 <= wr_data;
                else        mem0 <= wr_data;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, wr_en} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/ramb16_s36_stream_reader.sv
// Port-B read engine for a RAMB16_S2_S36: streams LEN words from BASE (wrapping) with last/done.
// Optional parity checking is built when PARITY_CHECK_EN is defined.
module ramb16_s36_stream_reader #(
    parameter int ADDR_W = ramb16_rd_pkg::ADDR_W,
    parameter int LEN_W  = ramb16_rd_pkg::LEN_W
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            START,
    input  logic [ADDR_W-1:0]               BASE,
    input  logic [LEN_W-1:0]                LEN,
    output logic                            BUSY,
    output logic                            DONE,
    output logic [ADDR_W-1:0]               ADDRB,
    output logic                            ENB,
    output logic                            WEB,
    output logic                            SSRB,
    input  logic [31:0]                     DOB,
    input  logic [3:0]                      DOPB,
    output logic [ramb16_rd_pkg::DATA_W-1:0] DOUT,
    output logic                            DOUT_VALID,
    input  logic                            DOUT_READY,
    output logic                            DOUT_LAST,
    output logic                            PERR
);
    import ramb16_rd_pkg::*;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  rem;
    logic              rd_vld;
    logic              rd_tag;
    logic              issue_last;
    logic              pop;
    logic              can_issue;
    logic [1:0]        occ;
    logic [DATA_W:0]   head;

    assign WEB   = 1'b0;
    assign SSRB  = 1'b0;
    assign ADDRB = addr;

    assign pop        = DOUT_VALID & DOUT_READY;
    assign issue_last = (rem == LEN_W'(1));

    // Words held after this cycle: buffered, plus the one on DOB, minus the one leaving.
    // Including the pop keeps ENB high back-to-back when the consumer is ready.
    assign can_issue = ({1'b0, occ} + {2'b0, rd_vld} - {2'b0, pop}) < 3'd2;
    assign ENB       = (state == READ) && can_issue;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            addr  <= '0;
            rem   <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        if (LEN == '0) begin
                            DONE <= 1'b1;
                        end else begin
                            BUSY  <= 1'b1;
                            addr  <= BASE;
                            rem   <= LEN;
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (ENB) begin
                        addr <= addr + ADDR_W'(1);
                        rem  <= rem - LEN_W'(1);
                        if (issue_last) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && DOUT_LAST) begin
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One-stage tag pipe: the RAM presents DOB the cycle after ENB.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_vld <= 1'b0;
            rd_tag <= 1'b0;
        end else begin
            rd_vld <= ENB;
            rd_tag <= ENB & issue_last;
        end
    end

    ramb16_rd_skid #(.W(DATA_W + 1)) u_skid (
        .clk      (CLK),
        .rst      (RST),
        .wr_en    (rd_vld),
        .wr_data  ({rd_tag, DOPB, DOB}),
        .rd_data  (head),
        .rd_valid (DOUT_VALID),
        .rd_ready (DOUT_READY),
        .occ      (occ)
    );

    assign DOUT_LAST = head[DATA_W];
    assign DOUT      = head[DATA_W-1:0];

`ifdef PARITY_CHECK_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            PERR <= 1'b0;
        end else if (state == IDLE && START) begin
            PERR <= 1'b0;
        end else if (rd_vld && word_par_err(DOB, DOPB)) begin
            PERR <= 1'b1;
        end
    end
`else
    assign PERR = 1'b0;
`endif

endmodule

// File: tb/tb_ramb16_s36_stream_reader.sv
// Self-checking bench: RAM model plus a queue-based expected-stream scoreboard.
module tb_ramb16_s36_stream_reader;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [8:0]  BASE = '0;
    logic [9:0]  LEN = '0;
    logic        BUSY, DONE, ENB, WEB, SSRB;
    logic [8:0]  ADDRB;
    logic [31:0] DOB = '0;
    logic [3:0]  DOPB = '0;
    logic [35:0] DOUT;
    logic        DOUT_VALID, DOUT_LAST, PERR;
    logic        DOUT_READY = 1'b1;

    always #5 CLK = ~CLK;

    ramb16_s36_stream_reader dut (
        .CLK(CLK), .RST(RST), .START(START), .BASE(BASE), .LEN(LEN),
        .BUSY(BUSY), .DONE(DONE), .ADDRB(ADDRB), .ENB(ENB), .WEB(WEB), .SSRB(SSRB),
        .DOB(DOB), .DOPB(DOPB), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID),
        .DOUT_READY(DOUT_READY), .DOUT_LAST(DOUT_LAST), .PERR(PERR)
    );

    logic [35:0] ram [512];
    always @(posedge CLK) begin
        if (ENB) begin
            DOB  <= ram[ADDRB][31:0];
            DOPB <= ram[ADDRB][35:32];
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference stream: every launched transfer appends its address list and word list.
    logic [36:0] exp_q[$];
    logic [8:0]  addr_q[$];
    int          issued = 0, accepted = 0, acc_total = 0;
    logic        prev_stall = 0, prev_last_hs = 0, zero_armed = 0, zero_due = 0;
    logic [36:0] prev_word = '0;

    always @(negedge CLK) begin
        logic [36:0] w;
        if (RST) begin
            issued = 0; accepted = 0; prev_stall = 0; prev_last_hs = 0; zero_due = 0;
        end else begin
            chk("done_pulse", DONE, prev_last_hs | zero_due);
            zero_due = zero_armed && START;
            if (prev_stall) begin
                chk("stall_valid_held", DOUT_VALID, 1'b1);
                chk("stall_word_held", {DOUT_LAST, DOUT}, prev_word);
            end
            prev_last_hs = 1'b0;
            if (DOUT_VALID && DOUT_READY) begin
                if (exp_q.size() == 0) chk("word_unexpected", DOUT_VALID, 1'b0);
                else begin
                    w = exp_q.pop_front();
                    chk("word_data_last", {DOUT_LAST, DOUT}, w);
                    prev_last_hs = w[36];
                end
                accepted++; acc_total++;
            end
            if (ENB) begin
                issued++;
                if (addr_q.size() == 0) chk("enb_unexpected", ENB, 1'b0);
                else chk("addrb", ADDRB, addr_q.pop_front());
                chk("held_le_2", (issued - accepted) <= 2, 1'b1);
            end
            chk("web_ssrb", {WEB, SSRB}, 2'b00);
`ifndef PARITY_CHECK_EN
            chk("perr_tied", PERR, 1'b0);
`endif
            prev_stall = DOUT_VALID && !DOUT_READY;
            prev_word  = {DOUT_LAST, DOUT};
        end
    end

    task automatic step();
        @(posedge CLK); #1;
    endtask

    task automatic launch(input logic [8:0] b, input logic [9:0] l);
        for (int i = 0; i < int'(l); i++) begin
            exp_q.push_back({(i == int'(l) - 1), ram[(int'(b) + i) % 512]});
            addr_q.push_back(9'(int'(b) + i));
        end
        BASE = b; LEN = l; START = 1'b1;
        step();
        START = 1'b0;
    endtask

    // mode 0: ready held high; 1: pattern 1,0,0 repeating; 2: random
    task automatic wait_done(input string tag, input int mode, input int budget);
        int  c;
        bit  seen;
        c = 0; seen = 0;
        while (!seen && c < budget) begin
            case (mode)
                0:       DOUT_READY = 1'b1;
                1:       DOUT_READY = (c % 3 == 0);
                default: DOUT_READY = 1'($urandom_range(0, 1));
            endcase
            step();
            c++;
            if (DONE) seen = 1;
        end
        DOUT_READY = 1'b1;
        chk({tag, "_done_seen"}, seen, 1'b1);
        chk({tag, "_words_left"}, exp_q.size(), 0);
        chk({tag, "_reads_left"}, addr_q.size(), 0);
        chk({tag, "_busy_low"}, BUSY, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, c;
        for (int i = 0; i < 512; i++) begin
            logic [31:0] d;
            logic [3:0]  p;
            d = $urandom;
            for (int j = 0; j < 4; j++) p[j] = ^d[8*j +: 8];
            ram[i] = {p, d};
        end

        #1 RST = 1'b1;
        step(); step();
        chk("rst_outputs", {BUSY, DONE, ENB, ADDRB, DOUT_VALID, DOUT_LAST, PERR}, '0);
        chk("rst_dout", DOUT, 36'h0);
        RST = 1'b0;
        step();

        // Exact cycle timing: BASE=0x010, LEN=4, ready high.
        launch(9'h010, 10'd4);
        chk("t1_busy_c0", BUSY, 1'b1);
        chk("t1_enb_c0", ENB, 1'b1);
        chk("t1_addrb_c0", ADDRB, 9'h010);
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("t1_enb_c%0d", k), ENB, (k < 4));
            chk($sformatf("t1_valid_c%0d", k), DOUT_VALID, (k >= 2 && k <= 5));
            chk($sformatf("t1_last_c%0d", k), DOUT_LAST & DOUT_VALID, (k == 5));
            chk($sformatf("t1_done_c%0d", k), DONE, (k == 6));
            chk($sformatf("t1_busy_c%0d", k), BUSY, (k < 6));
        end
        chk("t1_words_left", exp_q.size(), 0);

        // Address wrap at 512.
        launch(9'h1FE, 10'd4);
        wait_done("wrap", 0, 40);

        // Toggling backpressure.
        acc0 = acc_total;
        launch(9'h0A0, 10'd8);
        wait_done("bp8", 1, 100);
        chk("bp8_count", acc_total - acc0, 8);

        // Zero-length command.
        zero_armed = 1'b1;
        launch(9'h005, 10'd0);
        zero_armed = 1'b0;
        chk("len0_done", DONE, 1'b1);
        chk("len0_busy", BUSY, 1'b0);
        chk("len0_enb", ENB, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("len0_after", {DONE, BUSY, ENB}, 3'b000);
        end

        // Ignored START mid-transfer, then reset at word 5.
        acc0 = acc_total;
        launch(9'h040, 10'd16);
        c = 0;
        while ((acc_total - acc0) < 5 && c < 200) begin
            DOUT_READY = (c % 3 == 0);
            if (c == 3) begin BASE = 9'h100; LEN = 10'd3; START = 1'b1; end
            else START = 1'b0;
            step();
            c++;
        end
        START = 1'b0;
        chk("rst5_reached", (acc_total - acc0) >= 5, 1'b1);
        chk("rst5_still_busy", BUSY, 1'b1);
        RST = 1'b1;
        exp_q.delete();
        addr_q.delete();
        #1;
        chk("rst5_outputs", {BUSY, DONE, ENB, ADDRB, DOUT_VALID, DOUT_LAST, PERR}, '0);
        chk("rst5_dout", DOUT, 36'h0);
        DOUT_READY = 1'b1;
        step(); step();
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_idle", {DONE, BUSY, ENB, DOUT_VALID}, 4'b0000);
        end
        launch(9'h020, 10'd2);
        wait_done("post_rst", 0, 20);

        // Randomized transfers with random ready.
        for (int t = 0; t < 6; t++) begin
            acc0 = acc_total;
            launch(9'($urandom_range(0, 511)), 10'($urandom_range(1, 24)));
            wait_done($sformatf("rnd%0d", t), 2, 300);
        end
        launch(9'($urandom_range(0, 511)), 10'd512);
        wait_done("full512", 0, 600);

`ifdef PARITY_CHECK_EN
        ram[3][33] = ~ram[3][33];
        launch(9'h000, 10'd6);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("perr_c%0d", k), PERR, (k >= 5));
        end
        wait_done("perr_xfer", 0, 20);
        step();
        chk("perr_sticky", PERR, 1'b1);
        ram[3][33] = ~ram[3][33];
        launch(9'h010, 10'd2);
        chk("perr_cleared", PERR, 1'b0);
        wait_done("perr_clean", 0, 20);
        chk("perr_clean_end", PERR, 1'b0);
`endif

        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
